cdb_broadcaster: RTL and testbench

Result broadcaster that drives the four 23-bit forward buses consumed by the issue queues, reservation stations and reorder buffer. Completed results from up to NUM_SRC execution units (ALUs, load unit, etc.) are buffered in per-source FIFOs. Each cycle, a rotating-priority arbiter selects up to four of those FIFOs and broadcasts their heads as `{valid, rob[5:0], value[15:0]}` packets on forwardA..forwardD.

---
 rtl/cdb_broadcaster_pkg.sv | 36 +++
 rtl/cdb_broadcaster_fifo.sv | 64 ++++++
 rtl/cdb_broadcaster.sv | 111 +++++++++++
 tb/tb_cdb_broadcaster.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared forward-bus definitions used by the broadcaster and every forward-bus consumer.
//   TAG_W / VAL_W   : ROB tag and result value widths
//   FWD_W           : forward packet width {valid, rob, value}
//   FWD_VALID_BIT   : position of the valid bit in a forward packet
//   packFwd/unpackFwd : forward packet layout helpers
package cdb_broadcaster_pkg;

  localparam int unsigned TAG_W         = 6;
  localparam int unsigned VAL_W         = 16;
  localparam int unsigned ENTRY_W       = TAG_W + VAL_W;
  localparam int unsigned FWD_W         = 23;
  localparam int unsigned FWD_VALID_BIT = 22;
  localparam int unsigned NUM_BUS       = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob;
    logic [VAL_W-1:0] value;
  } fwdPkt_t;

  // Invalid packets carry an all-zero tag and value.
  function automatic logic [FWD_W-1:0] packFwd(input logic valid, input logic [ENTRY_W-1:0] entry);
    fwdPkt_t p;
    p = '0;
    if (valid) begin
      p.valid            = 1'b1;
      {p.rob, p.value}   = entry;
    end
    return p;
  endfunction

  function automatic fwdPkt_t unpackFwd(input logic [FWD_W-1:0] bus);
    return fwdPkt_t'(bus);
  endfunction

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// result_fifo: per-source result buffer {rob, value}.
//   clk, reset (async, active-high), flush (sync clear)
//   push/dataIn : enqueue when not full
//   pop/dataOut : dequeue head when not empty; dataOut shows the current head
//   count/full/empty : occupancy from registered state
module result_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] dataIn,
  output logic [ENTRY_W-1:0] dataOut,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic               doPush;
  logic               doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dataOut = mem[rdPtr];
  assign doPush  = push && !full && !flush;
  assign doPop   = pop && !empty && !flush;

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= dataIn;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: buffers results from NUM_SRC producers and broadcasts up to
// four per cycle on forwardA..D using a rotating-priority arbiter.
//   clk, reset (async, active-high), flush (sync discard of everything)
//   srcValid/srcROB/srcValue : per-source result inputs
//   srcReady                 : per-source FIFO not full (registered count)
//   forwardA..D              : registered {valid, rob, value} packets
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_SRC-1:0]       srcValid,
  input  logic [TAG_W*NUM_SRC-1:0] srcROB,
  input  logic [VAL_W*NUM_SRC-1:0] srcValue,
  output logic [NUM_SRC-1:0]       srcReady,
  output logic [FWD_W-1:0]         forwardA,
  output logic [FWD_W-1:0]         forwardB,
  output logic [FWD_W-1:0]         forwardC,
  output logic [FWD_W-1:0]         forwardD
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [ENTRY_W-1:0] head  [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];

  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   rrNext;
  logic [NUM_SRC-1:0] rotReq;
  logic [IDX_W-1:0]   busSrc [NUM_BUS];
  logic [NUM_BUS-1:0] busHit;
  logic [2:0]         slot;
  logic [FWD_W-1:0]   fwdReg [NUM_BUS];

  // Source index rr+offset modulo NUM_SRC (offset < NUM_SRC + 1).
  function automatic logic [IDX_W-1:0] wrapIdx(input int x);
    return IDX_W'((x >= int'(NUM_SRC)) ? (x - int'(NUM_SRC)) : x);
  endfunction

  // Per-source FIFOs; srcReady does not credit a same-cycle pop.
  for (genvar g = 0; g < int'(NUM_SRC); g++) begin : gSrc
    assign srcReady[g] = (count[g] != CNT_W'(FIFO_DEPTH));
    assign push[g]     = srcValid[g] && !full[g];

    result_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push    (push[g]),
      .pop     (pop[g]),
      .dataIn  ({srcROB[TAG_W*g +: TAG_W], srcValue[VAL_W*g +: VAL_W]}),
      .dataOut (head[g]),
      .count   (count[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // Rotate the request vector to start at rr, take the first four, unrotate.
  always_comb begin
    rotReq = '0;
    busHit = '0;
    pop    = '0;
    rrNext = rr;
    slot   = '0;
    for (int b = 0; b < int'(NUM_BUS); b++) busSrc[b] = '0;

    for (int k = 0; k < int'(NUM_SRC); k++) rotReq[k] = !empty[wrapIdx(int'(rr) + k)];

    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (rotReq[k] && (slot < 3'(NUM_BUS))) begin
        busHit[slot[1:0]]           = 1'b1;
        busSrc[slot[1:0]]           = wrapIdx(int'(rr) + k);
        pop[wrapIdx(int'(rr) + k)]  = 1'b1;
        rrNext                      = wrapIdx(int'(rr) + k + 1);
        slot                        = slot + 3'(1);
      end
    end

    if (flush) pop = '0;
  end

  // Pointer and output bus registers; flush and reset kill all bus valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= '0;
      for (int b = 0; b < int'(NUM_BUS); b++) fwdReg[b] <= '0;
    end else if (flush) begin
      rr <= '0;
      for (int b = 0; b < int'(NUM_BUS); b++) fwdReg[b] <= '0;
    end else begin
      rr <= rrNext;
      for (int b = 0; b < int'(NUM_BUS); b++) fwdReg[b] <= packFwd(busHit[b], head[busSrc[b]]);
    end
  end

  assign forwardA = fwdReg[0];
  assign forwardB = fwdReg[1];
  assign forwardC = fwdReg[2];
  assign forwardD = fwdReg[3];

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster.
// A default-depth instance is tracked by a scoreboard of accepted packets; a
// depth-2 instance sharing the same inputs is used for backpressure, since with
// four buses and round-robin priority a depth-4 FIFO is serviced too often to fill.
module tb_cdb_broadcaster;

  typedef struct packed {
    logic [2:0]  src;
    logic [21:0] data;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [5:0]  srcValid;
  logic [35:0] srcROB;
  logic [95:0] srcValue;
  logic [5:0]  srcReady;
  logic [5:0]  smallReady;
  logic [22:0] fwdA, fwdB, fwdC, fwdD;
  logic [22:0] sA, sB, sC, sD;
  logic [22:0] fwd  [4];
  logic [22:0] sfwd [4];

  sbEntry_t sbq [$];
  int  nChecks = 0;
  int  nPass   = 0;
  bit  monEn   = 1'b0;
  int  monHit;
  bit  monOrdered;

  always #5 clk = ~clk;

  cdb_broadcaster #(.NUM_SRC(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .srcValid(srcValid), .srcROB(srcROB), .srcValue(srcValue),
    .srcReady(srcReady),
    .forwardA(fwdA), .forwardB(fwdB), .forwardC(fwdC), .forwardD(fwdD)
  );

  cdb_broadcaster #(.NUM_SRC(6), .FIFO_DEPTH(2)) dutSmall (
    .clk(clk), .reset(reset), .flush(flush),
    .srcValid(srcValid), .srcROB(srcROB), .srcValue(srcValue),
    .srcReady(smallReady),
    .forwardA(sA), .forwardB(sB), .forwardC(sC), .forwardD(sD)
  );

  assign fwd[0]  = fwdA;
  assign fwd[1]  = fwdB;
  assign fwd[2]  = fwdC;
  assign fwd[3]  = fwdD;
  assign sfwd[0] = sA;
  assign sfwd[1] = sB;
  assign sfwd[2] = sC;
  assign sfwd[3] = sD;

  // Scoreboard: every valid packet must be pending, and no older packet of the same source may remain.
  always @(negedge clk) begin
    if (monEn) begin
      for (int b = 0; b < 4; b++) begin
        if (fwd[b][22]) begin
          monHit     = -1;
          monOrdered = 1'b1;
          for (int i = 0; i < sbq.size(); i++)
            if (monHit < 0 && sbq[i].data == fwd[b][21:0]) monHit = i;
          if (monHit >= 0)
            for (int j = 0; j < monHit; j++)
              if (sbq[j].src == sbq[monHit].src) monOrdered = 1'b0;
          nChecks++;
          if (monHit < 0 || !monOrdered)
            $display("FAIL scoreboard bus%0d: got %h, required a pending packet in source order (hit=%0d ordered=%0d)",
                     b, fwd[b], monHit, monOrdered);
          else begin
            nPass++;
            sbq.delete(monHit);
          end
        end else begin
          nChecks++;
          if (fwd[b][21:0] !== 22'h0)
            $display("FAIL idle_payload bus%0d: got %h, required 0", b, fwd[b]);
          else nPass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    srcValid = '0;
    srcROB   = '0;
    srcValue = '0;
  endtask

  task automatic setPush(input int s, input logic [5:0] rob, input logic [15:0] val, input bit expectAccept);
    srcValid[3'(s)]       = 1'b1;
    srcROB[6*s +: 6]      = rob;
    srcValue[16*s +: 16]  = val;
    if (expectAccept) sbq.push_back('{src: 3'(s), data: {rob, val}});
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    idle();
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== 23'h0) $display("FAIL reset_bus%0d: got %h, required 0", b, fwd[b]);
      else nPass++;
    end
    nChecks++;
    if (srcReady !== 6'h3F) $display("FAIL reset_ready: got %b, required 111111", srcReady);
    else nPass++;
    nChecks++;
    if (smallReady !== 6'h3F) $display("FAIL reset_ready_small: got %b, required 111111", smallReady);
    else nPass++;
    reset = 1'b0;
    monEn = 1'b1;
  endtask

  task automatic test_single();
    logic [22:0] exp [4];
    setPush(2, 6'h05, 16'hBEEF, 1'b1);
    tick();
    idle();
    nChecks++;
    if (fwdA[22] !== 1'b0) $display("FAIL single_latency: got valid %b one cycle after push, required 0", fwdA[22]);
    else nPass++;
    tick();
    exp[0] = {1'b1, 6'h05, 16'hBEEF};
    exp[1] = '0; exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL single bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    tick();
    nChecks++;
    if (fwdA !== 23'h0) $display("FAIL single_hold: got %h, required 0", fwdA);
    else nPass++;
  endtask

  task automatic test_six();
    logic [22:0] exp [4];
    doFlush();
    for (int s = 0; s < 6; s++) setPush(s, 6'(16 + s), 16'(24576 + s), 1'b1);
    tick();
    idle();
    tick();
    for (int b = 0; b < 4; b++) exp[b] = {1'b1, 6'(16 + b), 16'(24576 + b)};
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL six_first bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    tick();
    exp[0] = {1'b1, 6'h14, 16'h6004};
    exp[1] = {1'b1, 6'h15, 16'h6005};
    exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL six_second bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    // rr must have wrapped to 0, so source 0 outranks source 1.
    setPush(1, 6'h18, 16'h6101, 1'b1);
    setPush(0, 6'h19, 16'h6100, 1'b1);
    tick();
    idle();
    tick();
    exp[0] = {1'b1, 6'h19, 16'h6100};
    exp[1] = {1'b1, 6'h18, 16'h6101};
    exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL six_rr_wrap bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    tick();
  endtask

  // Source 3 is starved once so it holds two entries, then pushed and granted together.
  task automatic test_push_pop_backpressure();
    logic [22:0] exp [4];
    doFlush();
    setPush(3, 6'h20, 16'h3000, 1'b1);
    tick();
    idle();
    setPush(3, 6'h21, 16'h3001, 1'b1);
    setPush(4, 6'h24, 16'h4000, 1'b1);
    setPush(5, 6'h25, 16'h5000, 1'b1);
    setPush(0, 6'h26, 16'h0A00, 1'b1);
    setPush(1, 6'h27, 16'h1A00, 1'b1);
    tick();
    idle();
    nChecks++;
    if (fwdA !== {1'b1, 6'h20, 16'h3000}) $display("FAIL pp_p0: got %h, required %h", fwdA, {1'b1, 6'h20, 16'h3000});
    else nPass++;
    setPush(3, 6'h22, 16'h3002, 1'b1);
    tick();
    idle();
    exp[0] = {1'b1, 6'h24, 16'h4000};
    exp[1] = {1'b1, 6'h25, 16'h5000};
    exp[2] = {1'b1, 6'h26, 16'h0A00};
    exp[3] = {1'b1, 6'h27, 16'h1A00};
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL pp_starve bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
      nChecks++;
      if (sfwd[b] !== exp[b]) $display("FAIL pp_starve_small bus%0d: got %h, required %h", b, sfwd[b], exp[b]);
      else nPass++;
    end
    nChecks++;
    if (srcReady[3] !== 1'b1) $display("FAIL pp_ready_cnt2: got %b, required 1", srcReady[3]);
    else nPass++;
    nChecks++;
    if (smallReady[3] !== 1'b0) $display("FAIL bp_ready_full: got %b, required 0", smallReady[3]);
    else nPass++;
    // Pushed while source 3 is granted; the depth-2 copy is full and drops it.
    setPush(3, 6'h23, 16'h3003, 1'b1);
    tick();
    idle();
    exp[0] = {1'b1, 6'h21, 16'h3001};
    exp[1] = '0; exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL pp_p1 bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    nChecks++;
    if (sA !== exp[0]) $display("FAIL bp_p1_small: got %h, required %h", sA, exp[0]);
    else nPass++;
    nChecks++;
    if (smallReady[3] !== 1'b1) $display("FAIL bp_ready_back: got %b, required 1", smallReady[3]);
    else nPass++;
    tick();
    nChecks++;
    if (fwdA !== {1'b1, 6'h22, 16'h3002}) $display("FAIL pp_p2: got %h, required %h", fwdA, {1'b1, 6'h22, 16'h3002});
    else nPass++;
    nChecks++;
    if (sA !== {1'b1, 6'h22, 16'h3002}) $display("FAIL bp_p2_small: got %h, required %h", sA, {1'b1, 6'h22, 16'h3002});
    else nPass++;
    tick();
    nChecks++;
    if (fwdA !== {1'b1, 6'h23, 16'h3003}) $display("FAIL pp_p3: got %h, required %h", fwdA, {1'b1, 6'h23, 16'h3003});
    else nPass++;
    nChecks++;
    if (sA !== 23'h0) $display("FAIL bp_dropped_small: got %h, required 0", sA);
    else nPass++;
    tick();
    nChecks++;
    if (sbq.size() != 0) $display("FAIL pp_drain: got %0d pending, required 0", sbq.size());
    else nPass++;
  endtask

  task automatic test_flush();
    logic [22:0] exp [4];
    doFlush();
    setPush(0, 6'h30, 16'h0B00, 1'b1);
    setPush(5, 6'h35, 16'h5B00, 1'b1);
    tick();
    idle();
    setPush(0, 6'h31, 16'h0B01, 1'b0);
    setPush(5, 6'h36, 16'h5B01, 1'b0);
    tick();
    idle();
    exp[0] = {1'b1, 6'h30, 16'h0B00};
    exp[1] = {1'b1, 6'h35, 16'h5B00};
    exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL flush_pre bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    flush = 1'b1;
    setPush(0, 6'h32, 16'h0B02, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== 23'h0) $display("FAIL flush_bus%0d: got %h, required 0", b, fwd[b]);
      else nPass++;
    end
    nChecks++;
    if (srcReady !== 6'h3F) $display("FAIL flush_ready: got %b, required 111111", srcReady);
    else nPass++;
    nChecks++;
    if (smallReady !== 6'h3F) $display("FAIL flush_ready_small: got %b, required 111111", smallReady);
    else nPass++;
    for (int c = 0; c < 4; c++) tick();
    setPush(5, 6'h37, 16'h5B03, 1'b1);
    setPush(0, 6'h33, 16'h0B03, 1'b1);
    tick();
    idle();
    tick();
    exp[0] = {1'b1, 6'h33, 16'h0B03};
    exp[1] = {1'b1, 6'h37, 16'h5B03};
    exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL flush_resume bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [22:0] exp [4];
    for (int s = 0; s < 4; s++) setPush(s, 6'(56 + s), 16'(49152 + s), 1'b1);
    tick();
    idle();
    setPush(4, 6'h3C, 16'hC004, 1'b0);
    setPush(5, 6'h3D, 16'hC005, 1'b0);
    tick();
    idle();
    for (int b = 0; b < 4; b++) exp[b] = {1'b1, 6'(56 + b), 16'(49152 + b)};
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL areset_before bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    #2 reset = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== 23'h0) $display("FAIL areset_async bus%0d: got %h, required 0", b, fwd[b]);
      else nPass++;
    end
    nChecks++;
    if (srcReady !== 6'h3F) $display("FAIL areset_ready: got %b, required 111111", srcReady);
    else nPass++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    setPush(4, 6'h3E, 16'hC104, 1'b1);
    tick();
    idle();
    tick();
    exp[0] = {1'b1, 6'h3E, 16'hC104};
    exp[1] = '0; exp[2] = '0; exp[3] = '0;
    for (int b = 0; b < 4; b++) begin
      nChecks++;
      if (fwd[b] !== exp[b]) $display("FAIL areset_resume bus%0d: got %h, required %h", b, fwd[b], exp[b]);
      else nPass++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_six();
    test_push_pop_backpressure();
    test_flush();
    test_async_reset();
    for (int c = 0; c < 3; c++) tick();
    nChecks++;
    if (sbq.size() != 0) $display("FAIL final_drain: got %0d pending, required 0", sbq.size());
    else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
